// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
`default_nettype none

package rf_wb_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] value;
   } wb_req_t;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_PIPE = 2'd1;
   localparam logic [1:0] GNT_AUX  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rf_wb_fifo.sv
// Circular buffer holding auxiliary write-back results, with per-entry valid
// flags and destination export so the arbiter can build a pending-register map.
`default_nettype none

module rf_wb_fifo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push_i,
   input  logic [ADDR_W-1:0]       push_dest_i,
   input  logic [DATA_W-1:0]       push_value_i,
   input  logic                    pop_i,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [ADDR_W-1:0]       head_dest_o,
   output logic [DATA_W-1:0]       head_value_o,
   output logic [DEPTH-1:0]        valid_o,
   output logic [DEPTH*ADDR_W-1:0] dest_vec_o
);
   import rf_wb_arbiter_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ADDR_W-1:0] dest_q  [DEPTH];
   logic [DATA_W-1:0] value_q [DEPTH];
   logic              do_push, do_pop;

   assign full_o  = (cnt_q == DEPTH_C);
   assign empty_o = (cnt_q == '0);
   // A full buffer never accepts, even if the head leaves this same cycle.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      valid_d = valid_q;
      cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push) begin
         wr_d          = wr_q + 1'b1;
         valid_d[wr_q] = 1'b1;
      end
      if (do_pop) begin
         rd_d          = rd_q + 1'b1;
         valid_d[rd_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         valid_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         dest_q[wr_q]  <= push_dest_i;
         value_q[wr_q] <= push_value_i;
      end
   end

   assign head_dest_o  = dest_q[rd_q];
   assign head_value_o = value_q[rd_q];
   assign valid_o      = valid_q;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_dest
         assign dest_vec_o[i*ADDR_W +: ADDR_W] = dest_q[i];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between the WB stage and a buffered
// auxiliary result source. Optional same-cycle aux bypass: RF_WB_ARB_BYPASS_EN.
`default_nettype none

module rf_wb_arbiter #(
   parameter int DATA_W       = rf_wb_arbiter_pkg::DATA_W,
   parameter int ADDR_W       = rf_wb_arbiter_pkg::ADDR_W,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pipe_wb_en,
   input  logic [ADDR_W-1:0]    pipe_wb_dest,
   input  logic [DATA_W-1:0]    pipe_wb_value,
   output logic                 pipe_stall,
   input  logic                 aux_valid,
   output logic                 aux_ready,
   input  logic [ADDR_W-1:0]    aux_dest,
   input  logic [DATA_W-1:0]    aux_value,
   output logic                 WB_en,
   output logic [ADDR_W-1:0]    WB_dest,
   output logic [DATA_W-1:0]    WB_value,
   output logic [2**ADDR_W-1:0] busy_vec
);
   import rf_wb_arbiter_pkg::*;

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   logic [STARVE_W-1:0]          starve_q, starve_d;
   logic                         fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [ADDR_W-1:0]            head_dest;
   logic [DATA_W-1:0]            head_value;
   logic [FIFO_DEPTH-1:0]        ent_valid;
   logic [FIFO_DEPTH*ADDR_W-1:0] ent_dest;
   logic [1:0]                   gnt;
   logic                         stall_raw, wb_en_raw;

   rf_wb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (fifo_push),
      .push_dest_i  (aux_dest),
      .push_value_i (aux_value),
      .pop_i        (fifo_pop),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .head_dest_o  (head_dest),
      .head_value_o (head_value),
      .valid_o      (ent_valid),
      .dest_vec_o   (ent_dest)
   );

   assign aux_ready = ~fifo_full;

   always_comb begin
      gnt       = GNT_NONE;
      fifo_pop  = 1'b0;
      stall_raw = 1'b0;
      starve_d  = starve_q;
      if (fifo_empty) begin
         if (pipe_wb_en) begin
            gnt = GNT_PIPE;
         end
`ifdef RF_WB_ARB_BYPASS_EN
         else if (aux_valid) begin
            gnt = GNT_AUX;
         end
`endif
      end else if (!pipe_wb_en) begin
         gnt      = GNT_AUX;
         fifo_pop = 1'b1;
      end else if (starve_q < STARVE_MAX) begin
         gnt      = GNT_PIPE;
         starve_d = starve_q + 1'b1;
      end else begin
         // Head has waited long enough: steal the port and hold the pipeline.
         gnt       = GNT_AUX;
         fifo_pop  = 1'b1;
         stall_raw = 1'b1;
      end
      if (fifo_pop) begin
         starve_d = '0;
      end
   end

   // An aux grant while empty can only be the bypass path; it skips the buffer.
   assign fifo_push = aux_valid & ~fifo_full & ~(fifo_empty & (gnt == GNT_AUX));

   always_comb begin
      wb_en_raw = 1'b0;
      WB_dest   = pipe_wb_dest;
      WB_value  = pipe_wb_value;
      case (gnt)
         GNT_PIPE: wb_en_raw = 1'b1;
         GNT_AUX: begin
            wb_en_raw = 1'b1;
            if (fifo_empty) begin
               WB_dest  = aux_dest;
               WB_value = aux_value;
            end else begin
               WB_dest  = head_dest;
               WB_value = head_value;
            end
         end
         default: wb_en_raw = 1'b0;
      endcase
   end

   assign WB_en      = wb_en_raw & ~rst;
   assign pipe_stall = stall_raw & ~rst;

   always_comb begin
      busy_vec = '0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
         if (ent_valid[e]) begin
            busy_vec[ent_dest[e*ADDR_W +: ADDR_W]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the single register-file write port between the in-order pipeline write-back stage and an auxiliary multi-cycle result source, such as a multiplier or slow load unit. Pipeline writes normally win. Auxiliary results wait in a small FIFO and drain in idle write-back cycles. A starvation counter forces a pipeline stall so buffered results cannot wait forever. The block sits between the WB stage and the register file, drives its WB_en/WB_dest/WB_value inputs, and exports a pending-destination vector that decode uses for hazard stalls.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 4, register index width (2**ADDR_W registers)
- FIFO_DEPTH, 4, auxiliary buffer entries (power of two, ≥2)
- STARVE_LIMIT, 3, consecutive denied cycles before a forced auxiliary grant (≥1)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- pipe_wb_en  in  1  pipeline requests a write this cycle
- pipe_wb_dest  in  ADDR_W  pipeline destination
- pipe_wb_value  in  DATA_W  pipeline data
- pipe_stall  out  1  pipeline write refused this cycle; WB stage must hold and re-present it
- aux_valid  in  1  auxiliary result offered
- aux_ready  out  1  auxiliary result accepted when aux_valid & aux_ready at posedge
- aux_dest  in  ADDR_W  auxiliary destination
- aux_value  in  DATA_W  auxiliary data
- WB_en  out  1  register-file write enable
- WB_dest  out  ADDR_W  register-file write index
- WB_value  out  DATA_W  register-file write data
- busy_vec  out  2**ADDR_W  bit r set if any valid FIFO entry targets register r

## Operation
- The FIFO is a circular buffer with read/write pointers and a count. aux_ready = !full and depends only on state. If the FIFO is full, no enqueue happens even when a dequeue occurs in the same cycle.
- Grant, combinational each cycle:
  - The FIFO is empty: the pipeline is passed through. WB_* = pipe_*.
  - The FIFO is non-empty, pipe_wb_en=0: the FIFO head is written and dequeued.
  - The FIFO is non-empty, pipe_wb_en=1, starve_cnt<STARVE_LIMIT: the pipeline is written. starve_cnt increments.
  - The FIFO is non-empty, pipe_wb_en=1, starve_cnt==STARVE_LIMIT: the head is written and dequeued. pipe_stall=1 and starve_cnt clears.
- starve_cnt clears on every dequeue. It saturates at STARVE_LIMIT.
- pipe_stall is only ever 1 when pipe_wb_en=1.
- busy_vec is the OR of one-hot(dest) over valid entries. It is registered state derived from the FIFO contents, not from the incoming aux_dest.
- Enqueue and dequeue in the same cycle is legal when not full. The count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Pipeline path: zero latency, combinational pass-through.
- Auxiliary path, without bypass: an accepted result is written at the earliest in the next cycle.
- Worst-case drain of the head: STARVE_LIMIT+1 cycles after it reaches the head.
- Reset effects:
  - The FIFO is emptied and starve_cnt=0.
  - busy_vec=0 and aux_ready=1.
  - While rst is high, WB_en=0 and pipe_stall=0 are forced.
  - Reset asserted mid-operation discards buffered results.
- The register file samples on negedge clk. All WB_* outputs settle within the posedge-to-negedge half cycle.

## Configuration
- RF_WB_ARB_BYPASS_EN defined:
  - When the FIFO is empty, pipe_wb_en=0 and aux_valid=1, the auxiliary result is written directly in the same cycle (WB_* = aux_*) and is not enqueued.
  - aux_ready is still !full.
- RF_WB_ARB_BYPASS_EN undefined: every auxiliary result passes through the FIFO.

## Structure
- Shared package holds:
  - the wb_req_t typedef (en, dest, value);
  - the default widths DATA_W and ADDR_W;
  - the grant encoding constants GNT_NONE, GNT_PIPE, GNT_AUX.
- One sub-module: rf_wb_fifo. It is a synchronous FIFO with push/pop, full/empty, head outputs and an entry-valid vector. The top-level arbiter computes busy_vec from it.

## Test plan
- Pipeline only: pipe_wb_en=1, dest=5, value=0xA5 for 4 cycles -> WB_en=1, WB_dest=5, WB_value=0xA5 each cycle, pipe_stall=0.
- Idle drain: push aux dest=3, value=0x11; pipe idle next cycle -> WB_dest=3, WB_value=0x11 one cycle after acceptance; busy_vec[3] goes 1 then 0.
- Starvation: FIFO holds 1 entry, pipe_wb_en=1 continuously, STARVE_LIMIT=3 -> pipeline writes 3 cycles, 4th cycle aux written with pipe_stall=1, pipeline write lands on the 5th cycle.
- Full: push 4 aux entries with the pipeline busy -> aux_ready=0 after the 4th; a 5th offer is held and is accepted only after a dequeue frees an entry.
- Reset mid-operation: 2 entries buffered, assert rst -> WB_en=0, busy_vec=0, aux_ready=1 immediately; no buffered write after release.
- Bypass (macro defined): FIFO empty, pipe idle, aux_valid dest=7, value=0x77 -> written in the same cycle, busy_vec stays 0; without the macro the write lands in the next cycle.
